// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide controller.
// The divide datapath is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issuing stage and muldiv_ctrl.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic [XLEN-1:0] result_o;
    logic            result_valid_o;
    logic            result_ready_i;
    logic            busy_o;

    modport master (
        output valid_i, op_i, a_i, b_i, flush_i, result_ready_i,
        input  ready_o, result_o, result_valid_o, busy_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, flush_i, result_ready_i,
        output ready_o, result_o, result_valid_o, busy_o
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the radix-2 datapath: add-shift multiply or restoring divide step.
// The divide branch exists only when MULDIV_DIV_EN is defined.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
`ifdef MULDIV_DIV_EN
    input  logic              is_div,
`endif
    output logic [2*XLEN-1:0] acc_step
);

    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  mul_acc;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0]      shifted;
    logic               ge;
    logic [XLEN-1:0]    rem_new;
    logic [2*XLEN-1:0]  div_acc;
`endif

    always_comb begin
        // Upper half accumulates the multiplicand; carry enters at the top on the shift.
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        mul_acc = {mul_sum, acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        // acc = {remainder, dividend/quotient}; quotient bits shift in at the bottom.
        shifted  = acc[2*XLEN-1:XLEN-1];
        ge       = shifted >= {1'b0, operand};
        rem_new  = ge ? (shifted[XLEN-1:0] - operand) : shifted[XLEN-1:0];
        div_acc  = {rem_new, acc[XLEN-2:0], ge};
        acc_step = is_div ? div_acc : mul_acc;
`else
        acc_step = mul_acc;
`endif
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide controller: FSM, counter, operand registers, sign fix-up.
// Build option MULDIV_DIV_EN enables the divide/remainder operations.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    muldiv_if.slave   bus
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_FIN  = ST_FIN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         op_reg, op_next;
    logic [2*XLEN-1:0]  acc_reg, acc_next;
    logic [XLEN-1:0]    opb_reg, opb_next;
    logic               neg_res_reg, neg_res_next;
    logic [XLEN-1:0]    result_reg, result_next;
`ifdef MULDIV_DIV_EN
    logic               neg_rem_reg, neg_rem_next;
    logic               div0, ovf;
    logic [XLEN-1:0]    quot, rem;
`endif

    logic               a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic [2*XLEN-1:0]  step_acc, prod;
    logic [XLEN-1:0]    mul_res, fin_res;

    muldiv_step u_step (
        .acc      (acc_reg),
        .operand  (opb_reg),
`ifdef MULDIV_DIV_EN
        .is_div   (op_reg[2]),
`endif
        .acc_step (step_acc)
    );

    // Operand decode at acceptance: signed operands become magnitudes plus sign flags.
    always_comb begin
        a_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                   (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
        b_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
        a_neg    = a_signed && bus.a_i[XLEN-1];
        b_neg    = b_signed && bus.b_i[XLEN-1];
        a_mag    = a_neg ? -bus.a_i : bus.a_i;
        b_mag    = b_neg ? -bus.b_i : bus.b_i;
`ifdef MULDIV_DIV_EN
        div0     = bus.op_i[2] && (bus.b_i == '0);
        ovf      = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                   (bus.a_i == INT_MIN) && (bus.b_i == {XLEN{1'b1}});
`endif
    end

    always_comb begin
        prod    = neg_res_reg ? -acc_reg : acc_reg;
        mul_res = (op_reg[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        quot    = neg_res_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        rem     = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
        fin_res = op_reg[2] ? (op_reg[1] ? rem : quot) : mul_res;
`else
        fin_res = op_reg[2] ? '0 : mul_res;
`endif
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        op_next      = op_reg;
        acc_next     = acc_reg;
        opb_next     = opb_reg;
        neg_res_next = neg_res_reg;
        result_next  = result_reg;
`ifdef MULDIV_DIV_EN
        neg_rem_next = neg_rem_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (bus.valid_i && !bus.flush_i) begin
                    cnt_next     = '0;
                    op_next      = bus.op_i;
                    neg_res_next = a_neg ^ b_neg;
                    state_next   = S_CALC;
                    if (bus.op_i[2]) begin
                        acc_next = {{XLEN{1'b0}}, a_mag};
                        opb_next = b_mag;
`ifdef MULDIV_DIV_EN
                        neg_rem_next = a_neg;
                        if (div0) begin
                            result_next = bus.op_i[1] ? bus.a_i : DIV0_QUOT;
                            state_next  = S_DONE;
                        end else if (ovf) begin
                            result_next = bus.op_i[1] ? '0 : INT_MIN;
                            state_next  = S_DONE;
                        end
`else
                        result_next = '0;
                        state_next  = S_DONE;
`endif
                    end else begin
                        acc_next = {{XLEN{1'b0}}, b_mag};
                        opb_next = a_mag;
                    end
                end
            end
            S_CALC: begin
                acc_next = step_acc;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(XLEN-1)) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                result_next = fin_res;
                state_next  = S_DONE;
            end
            S_DONE: begin
                if (bus.result_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A flush kills whatever is in flight, including an unconsumed result.
        if (bus.flush_i && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            acc_reg     <= '0;
            opb_reg     <= '0;
            neg_res_reg <= 1'b0;
            result_reg  <= '0;
`ifdef MULDIV_DIV_EN
            neg_rem_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            op_reg      <= op_next;
            acc_reg     <= acc_next;
            opb_reg     <= opb_next;
            neg_res_reg <= neg_res_next;
            result_reg  <= result_next;
`ifdef MULDIV_DIV_EN
            neg_rem_reg <= neg_rem_next;
`endif
        end
    end

    assign bus.ready_o        = (state_reg == S_IDLE);
    assign bus.busy_o         = (state_reg != S_IDLE);
    assign bus.result_valid_o = (state_reg == S_DONE);
    assign bus.result_o       = result_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl; expectations switch on MULDIV_DIV_EN.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_if bus ();

    muldiv_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, measure latency to result_valid_o, optionally stall the consumer.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input int hold);
        int   cyc;
        logic busy_ok;
        logic hold_ok;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!bus.result_valid_o && cyc < 60) begin
            if (!bus.busy_o || bus.ready_o) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!bus.busy_o || bus.ready_o) busy_ok = 1'b0;
        $display("op=%0d a=%h b=%h result=%h latency=%0d", op, a, b, bus.result_o, cyc);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("result", bus.result_o, exp_res);
        check("busy_during_op", {31'd0, busy_ok}, 32'd1);
        hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (bus.result_o !== exp_res || !bus.result_valid_o || bus.ready_o) hold_ok = 1'b0;
        end
        if (hold > 0) check("hold_stable", {31'd0, hold_ok}, 32'd1);
        bus.result_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready_i = 1'b0;
        check("idle_after_take", {30'd0, bus.ready_o, bus.result_valid_o}, 32'd2);
    endtask

    initial begin
        int   cyc;
        logic seen;
        checks             = 0;
        errors             = 0;
        rst_n              = 1'b0;
        bus.valid_i        = 1'b0;
        bus.op_i           = 3'd0;
        bus.a_i            = '0;
        bus.b_i            = '0;
        bus.flush_i        = 1'b0;
        bus.result_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_valid", {31'd0, bus.result_valid_o}, 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
`ifdef MULDIV_DIV_EN
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 34, 0);
        run_op(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op(3'd6, 32'd100, 32'd0, 32'd100, 1, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 2);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
`else
        run_op(3'd6, 32'd9, 32'd4, 32'd0, 1, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 1, 0);
        run_op(3'd5, 32'd100, 32'd0, 32'd0, 1, 2);
`endif

        // Flush in cycle 10 of a long op.
`ifdef MULDIV_DIV_EN
        bus.op_i = 3'd5;
`else
        bus.op_i = 3'd3;
`endif
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd7;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        $display("flush issued: ready=%0d busy=%0d", bus.ready_o, bus.busy_o);
        check("flush_idle", {30'd0, bus.ready_o, bus.busy_o}, 32'd2);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid_o) seen = 1'b1;
        end
        check("flush_no_valid", {31'd0, seen}, 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, 0);

        // Flush held in IDLE blocks acceptance.
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.op_i    = 3'd0;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        check("flush_blocks_accept", {31'd0, bus.busy_o}, 32'd0);

        // Asynchronous reset in cycle 20.
        bus.op_i    = 3'd0;
        bus.a_i     = 32'd5;
        bus.b_i     = 32'd6;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        cyc = 1;
        repeat (19) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("pre_reset_busy", {31'd0, bus.busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        $display("reset asserted in cycle %0d: ready=%0d busy=%0d valid=%0d result=%h",
                 cyc, bus.ready_o, bus.busy_o, bus.result_valid_o, bus.result_o);
        check("async_rst_ready", {31'd0, bus.ready_o}, 32'd1);
        check("async_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("async_rst_valid", {31'd0, bus.result_valid_o}, 32'd0);
        check("async_rst_result", bus.result_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
